// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, baud divider helper and line idle level.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick divider, one-cycle tick every DIV clocks, synchronous clear.
module uart_rx_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to receive and check a parity bit (PARITY_ODD selects odd).
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err_o
`endif
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  rx_state_t            state;
  logic [1:0]           sync;
  logic [SW-1:0]        sample;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;
  logic                 rxs;
  logic                 tick;
  logic                 at_end;
  logic                 at_mid;
`ifdef UART_RX_PARITY_EN
  logic                 bad;
`endif
  assign rxs    = sync[1];
  assign at_end = sample == SW'(OVERSAMPLE - 1);
  assign at_mid = sample == SW'(OVERSAMPLE / 2 - 1);
  // Restarting the divider on the start edge keeps every sample point phase-locked to that edge.
  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE && !rxs),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync        <= {2{IDLE_LEVEL}};
      state       <= IDLE;
      sample      <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      deliver     <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad          <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], rx_i};
      deliver     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (tick) sample <= at_end ? '0 : sample + 1'b1;
      case (state)
        IDLE: if (!rxs) begin
          state  <= START;
          busy_o <= 1'b1;
          sample <= '0;
        end
        START: if (tick && at_mid) begin
          state   <= rxs ? IDLE : DATA;
          busy_o  <= !rxs;
          sample  <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          bad     <= 1'b0;
`endif
        end
        DATA: if (tick && at_end) begin
          shift   <= {rxs, shift[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == BW'(DATA_BITS - 1)) state <= PARITY;
`else
          if (bit_idx == BW'(DATA_BITS - 1)) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick && at_end) begin
          bad          <= (^shift ^ rxs) != PARITY_ODD;
          parity_err_o <= (^shift ^ rxs) != PARITY_ODD;
          state        <= STOP;
        end
`endif
        STOP: if (tick && at_end) begin
          state       <= rxs ? IDLE : WAIT_IDLE;
          busy_o      <= !rxs;
          frame_err_o <= !rxs;
`ifdef UART_RX_PARITY_EN
          deliver     <= rxs && !bad;
`else
          deliver     <= rxs;
`endif
        end
        WAIT_IDLE: if (rxs) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  // A held byte is never overwritten; the newcomer is dropped and flagged instead.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= deliver && valid_o && !ready_i;
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= shift;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit (DIV=1).
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, busy, fe, ov;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         fall_cyc = 0;
  int         lat_last = -1;
  int         vcyc[$];
  logic [9:0] exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx #(.CLK_FREQ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .busy_o     (busy),
    .frame_err_o(fe),
    .overrun_o  (ov)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  task automatic sb_pop(input logic [1:0] kind, input logic [7:0] d, input string name);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind %0d data %h, none required", name, kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, d}) begin
        errors++;
        $display("FAIL %s: got kind %0d data %h, required kind %0d data %h", name, kind, d, e[9:8], e[7:0]);
      end
    end
  endtask
  // Kinds: 0 = byte transferred, 1 = frame error, 2 = overrun.
  always @(negedge clk) if (rst_n) begin
    if (valid && ready) begin
      sb_pop(2'd0, data, "data");
      vcyc.push_back(cyc);
      lat_last = cyc - fall_cyc;
    end
    if (fe) sb_pop(2'd1, 8'h00, "frame_err");
    if (ov) sb_pop(2'd2, 8'h00, "overrun");
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = stop;
    step(16);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
  initial begin
    step(3);
    chk("reset_outputs", {24'h0, data} | {valid, busy, fe, ov, 28'h0}, 32'h0);
    rst_n = 1'b1;
    step(4);
    exp_q.push_back({2'd0, 8'hA5});
    send(8'hA5, 1'b1);
    step(4);
    chk("a5_latency_in_window", (lat_last >= 152 && lat_last <= 158), 1);
    chk("a5_one_transfer", vcyc.size(), 1);
    rx = 1'b0;
    fall_cyc = cyc;
    step(4);
    rx = 1'b1;
    step(1);
    chk("glitch_busy_high", busy, 1'b1);
    step(7);
    chk("glitch_busy_dropped", busy, 1'b0);
    step(20);
    chk("glitch_no_valid", valid, 1'b0);
    exp_q.push_back({2'd1, 8'h00});
    send(8'h3C, 1'b0);
    step(100);
    chk("wait_idle_busy", busy, 1'b1);
    chk("frame_err_no_valid", valid, 1'b0);
    rx = 1'b1;
    step(4);
    chk("wait_idle_released", busy, 1'b0);
    exp_q.push_back({2'd0, 8'h81});
    send(8'h81, 1'b1);
    step(10);
    ready = 1'b0;
    exp_q.push_back({2'd2, 8'h00});
    exp_q.push_back({2'd0, 8'h11});
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rx = 1'b1;
    step(5);
    chk("overrun_data_held", data, 8'h11);
    chk("overrun_valid_held", valid, 1'b1);
    ready = 1'b1;
    step(1);
    chk("overrun_valid_cleared", valid, 1'b0);
    step(10);
    vcyc.delete();
    exp_q.push_back({2'd0, 8'h00});
    exp_q.push_back({2'd0, 8'hFF});
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    step(5);
    chk("b2b_two_transfers", vcyc.size(), 2);
    if (vcyc.size() == 2) chk("b2b_spacing", vcyc[1] - vcyc[0], 160);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      step(16);
    end
    rx = 1'b1;
    step(8);
    chk("midframe_busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {valid, busy, fe, ov}, 4'h0);
    chk("midframe_reset_data", data, 8'h00);
    step(3);
    rst_n = 1'b1;
    step(3);
    exp_q.push_back({2'd0, 8'hC3});
    send(8'hC3, 1'b1);
    step(20);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the RS422 link: the receive-side counterpart of the transmit-side baud tick generator.
- Oversamples the synchronised line, detects start bits and samples each bit at mid-point.
- Delivers bytes on a valid/ready interface to the downstream consumer.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate in bits/s.
- OVERSAMPLE, 16, samples per bit; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame; LSB is sent first.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_i  input  1  serial line; asynchronous to clk; idles high.
- data_o  output  DATA_BITS  received byte; stable while valid_o=1.
- valid_o  output  1  byte available.
- ready_i  input  1  consumer accepts; a transfer occurs when valid_o && ready_i.
- busy_o  output  1  a frame is in progress (state ≠ IDLE).
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: new byte dropped because the previous byte was not yet taken.

Behaviour:
- Interface decision: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values:
  - data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - Synchroniser flops = 1; state = IDLE; all counters = 0.
- Synchroniser: 2-flop synchroniser on rx_i. All decisions use the synchronised value rxs.
- Oversample tick:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer-truncated, minimum 1.
  - Tick counter counts 0..DIV-1 and pulses one cycle at wrap.
  - Counter is cleared on entry to START so the bit phase aligns to the falling edge.
- Sample counter: 0..OVERSAMPLE-1, advances on each tick.
- FSM:
  - IDLE: when rxs=0 → START; clear tick and sample counters.
  - START: at tick with sample=OVERSAMPLE/2-1 (mid start bit):
    - rxs=1 → IDLE (glitch rejected, nothing reported).
    - rxs=0 → DATA; sample=0; bit index=0.
  - DATA: at tick with sample=OVERSAMPLE-1, shift rxs into the shift register MSB side (LSB-first framing). After DATA_BITS bits → STOP.
  - STOP: at mid stop bit (sample=OVERSAMPLE-1):
    - rxs=1 → deliver the byte → IDLE.
    - rxs=0 → frame_err_o pulse, byte discarded → WAIT_IDLE.
  - WAIT_IDLE: remain until rxs=1 (break/stuck-low protection), then → IDLE.
- Delivery happens on the cycle after the stop sample:
  - valid_o=0, or valid_o=1 && ready_i=1 in that cycle: load data_o, valid_o=1.
  - valid_o=1 && ready_i=0: keep the old data_o, pulse overrun_o; new byte lost.
- Handshake:
  - valid_o stays high until a transfer occurs; it clears the cycle after the transfer unless a new byte is loaded in the same cycle.
  - data_o does not change while valid_o=1 and no transfer occurs.
- Latency: valid_o rises at most DIV*OVERSAMPLE*(DATA_BITS+1.5)+4 clocks after the rx_i falling edge.
- Returning to IDLE at mid stop bit tolerates up to ±(OVERSAMPLE/2-1)/OVERSAMPLE bit of accumulated clock skew per frame.
- Reset mid-frame: all state is abandoned immediately. The next falling edge after release starts a fresh frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One parity bit is received after the data bits (state PARITY, sampled at mid-bit like the data bits).
  - Parameter PARITY_ODD (default 0 = even) selects the expected parity.
  - Extra output port parity_err_o (1 bit) pulses one cycle on mismatch; the byte is discarded and the FSM goes to STOP, stop-bit checking unchanged.
- Not defined: no PARITY state, no parity_err_o port, frame = start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - Function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE, clamped to ≥1.
  - Idle-level constant (1).
- Sub-module uart_rx_tick: oversample tick divider with a synchronous clear input. Reusable by a future transmitter.

Test Plan:
- Params CLK_FREQ=1843200, BAUD=115200, OVERSAMPLE=16 (DIV=1, 16 clk/bit), ready_i=1:
  - Send 0xA5 with a valid stop → valid_o one-cycle pulse with data_o=0xA5 within 155±3 clk of the falling edge; no error pulses.
- Drive rx_i low for 4 clk, then high → no valid_o; busy_o drops by clock 12; state returns to IDLE.
- Send 0x3C with stop bit low → frame_err_o single pulse, valid_o stays 0. Hold rx_i low 100 clk → busy_o stays 1 (WAIT_IDLE). Release → next byte 0x81 received correctly.
- ready_i=0; send 0x11 then 0x22 back-to-back → data_o=0x11, valid_o held high, overrun_o pulse at the end of 0x22. Raise ready_i → 0x11 transferred, valid_o falls.
- ready_i=1; back-to-back 0x00, 0xFF with no idle gap → two valid pulses, data 0x00 then 0xFF, exactly 160 clk apart.
- Assert rst_n low during bit 4 of 0x55 → all outputs 0 immediately. After release, send 0xC3 → data_o=0xC3 with no error pulses.
